// File: rtl/dec_ram_ctrl_if.sv
// dec_ram_ctrl_if: decoder write stream, consumer read stream and the DEC_RAM port
// grouped for dec_ram_ctrl. The slave modport is the controller's view.
interface dec_ram_ctrl_if #(
  parameter int A_WIDTH = 8
);
  logic               wr_valid;
  logic               wr_bit;
  logic               wr_ready;
  logic               rd_valid;
  logic               rd_bit;
  logic               rd_last;
  logic               rd_ready;
  logic [1:0]         bank_full;
  logic               ram_cs;
  logic               ram_we;
  logic               ram_rs;
  logic [A_WIDTH-1:0] ram_addr;
  logic               ram_din;
  logic               ram_dout;

  modport master (
    output wr_valid, wr_bit, rd_ready, ram_dout,
    input  wr_ready, rd_valid, rd_bit, rd_last, bank_full,
    input  ram_cs, ram_we, ram_rs, ram_addr, ram_din
  );

  modport slave (
    input  wr_valid, wr_bit, rd_ready, ram_dout,
    output wr_ready, rd_valid, rd_bit, rd_last, bank_full,
    output ram_cs, ram_we, ram_rs, ram_addr, ram_din
  );
endinterface

// File: rtl/dec_ram_ctrl.sv
// dec_ram_ctrl: ping-pong bank controller and single-port arbiter for the decision RAM.
// Define DEC_RAM_CTRL_WR_PRIO_EN to let writes win every contended cycle (default: round-robin).
module dec_ram_ctrl #(
  parameter int A_WIDTH = 8,
  parameter int N_BITS  = 256
) (
  input  logic          clk,
  input  logic          rst,
  dec_ram_ctrl_if.slave bus
);
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(N_BITS - 1);
  localparam logic [A_WIDTH-1:0] ADDR_ONE  = A_WIDTH'(1);

  logic               wb_r;
  logic               rb_r;
  logic [A_WIDTH-1:0] wa_r;
  logic [A_WIDTH-1:0] ra_r;
  logic [1:0]         bank_full_r;
  logic               rd_inflight_r;
  logic               inflight_last_r;
  logic [1:0]         fifo_bit_r;
  logic [1:0]         fifo_last_r;
  logic [1:0]         fifo_occ_r;
  logic               rs_hold_r;
  logic [A_WIDTH-1:0] addr_hold_r;

  logic       rd_valid_s;
  logic       pop_s;
  logic       we_req_s;
  logic       rd_req_s;
  logic       grant_wr_s;
  logic       grant_rd_s;
  logic [1:0] credit_s;

  assign rd_valid_s = !rst && (fifo_occ_r != 2'd0);
  assign pop_s      = rd_valid_s && bus.rd_ready;
  // The slot freed by this cycle's pop is counted so streaming sustains one bit per cycle.
  assign credit_s   = fifo_occ_r + {1'b0, rd_inflight_r} - {1'b0, pop_s};
  assign we_req_s   = bus.wr_valid && !bank_full_r[wb_r];
  assign rd_req_s   = bank_full_r[rb_r] && (credit_s < 2'd2);

`ifndef DEC_RAM_CTRL_WR_PRIO_EN
  logic last_grant_r;

  // Round-robin pointer: remembers the winner of the last contended cycle (1 = read).
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (we_req_s && rd_req_s) begin
      last_grant_r <= grant_rd_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Arbiter: one grant per cycle, nothing granted while in reset.
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (rst) begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end else if (we_req_s && rd_req_s) begin
`ifdef DEC_RAM_CTRL_WR_PRIO_EN
      grant_wr_s = 1'b1;
      grant_rd_s = 1'b0;
`else
      grant_wr_s = last_grant_r;
      grant_rd_s = !last_grant_r;
`endif
    end else begin
      grant_wr_s = we_req_s;
      grant_rd_s = rd_req_s;
    end
  end

  // RAM port drive; address and bank select hold their last value on idle cycles.
  always_comb begin
    bus.ram_cs   = grant_wr_s | grant_rd_s;
    bus.ram_we   = grant_wr_s;
    bus.ram_rs   = rs_hold_r;
    bus.ram_addr = addr_hold_r;
    if (rst) begin
      bus.ram_rs   = 1'b0;
      bus.ram_addr = {A_WIDTH{1'b0}};
    end else if (grant_wr_s) begin
      bus.ram_rs   = wb_r;
      bus.ram_addr = wa_r;
    end else if (grant_rd_s) begin
      bus.ram_rs   = rb_r;
      bus.ram_addr = ra_r;
    end else begin
      bus.ram_rs   = rs_hold_r;
      bus.ram_addr = addr_hold_r;
    end
  end

  assign bus.wr_ready  = grant_wr_s;
  assign bus.ram_din   = bus.wr_bit;
  assign bus.rd_valid  = rd_valid_s;
  assign bus.rd_bit    = rd_valid_s & fifo_bit_r[0];
  assign bus.rd_last   = rd_valid_s & fifo_last_r[0];
  assign bus.bank_full = bank_full_r;

  // Bank pointers, addresses, occupancy and the outstanding-read tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_r            <= 1'b0;
      rb_r            <= 1'b0;
      wa_r            <= {A_WIDTH{1'b0}};
      ra_r            <= {A_WIDTH{1'b0}};
      bank_full_r     <= 2'b00;
      rd_inflight_r   <= 1'b0;
      inflight_last_r <= 1'b0;
      rs_hold_r       <= 1'b0;
      addr_hold_r     <= {A_WIDTH{1'b0}};
    end else begin
      rd_inflight_r   <= grant_rd_s;
      inflight_last_r <= (ra_r == LAST_ADDR);
      if (grant_wr_s || grant_rd_s) begin
        rs_hold_r   <= bus.ram_rs;
        addr_hold_r <= bus.ram_addr;
      end
      if (grant_wr_s) begin
        if (wa_r == LAST_ADDR) begin
          wa_r              <= {A_WIDTH{1'b0}};
          wb_r              <= !wb_r;
          bank_full_r[wb_r] <= 1'b1;
        end else begin
          wa_r <= wa_r + ADDR_ONE;
        end
      end
      if (grant_rd_s) begin
        if (ra_r == LAST_ADDR) begin
          ra_r              <= {A_WIDTH{1'b0}};
          rb_r              <= !rb_r;
          bank_full_r[rb_r] <= 1'b0;
        end else begin
          ra_r <= ra_r + ADDR_ONE;
        end
      end
    end
  end

  // Two-entry output FIFO, head in slot 0; RAM data lands the cycle after its read grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_bit_r  <= 2'b00;
      fifo_last_r <= 2'b00;
      fifo_occ_r  <= 2'd0;
    end else begin
      case ({rd_inflight_r, pop_s})
        2'b10: begin
          fifo_bit_r[fifo_occ_r[0]]  <= bus.ram_dout;
          fifo_last_r[fifo_occ_r[0]] <= inflight_last_r;
          fifo_occ_r                 <= fifo_occ_r + 2'd1;
        end
        2'b01: begin
          fifo_bit_r[0]  <= fifo_bit_r[1];
          fifo_last_r[0] <= fifo_last_r[1];
          fifo_occ_r     <= fifo_occ_r - 2'd1;
        end
        2'b11: begin
          if (fifo_occ_r == 2'd1) begin
            fifo_bit_r[0]  <= bus.ram_dout;
            fifo_last_r[0] <= inflight_last_r;
          end else begin
            fifo_bit_r[0]  <= fifo_bit_r[1];
            fifo_last_r[0] <= fifo_last_r[1];
            fifo_bit_r[1]  <= bus.ram_dout;
            fifo_last_r[1] <= inflight_last_r;
          end
        end
        default: begin
          fifo_occ_r <= fifo_occ_r;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dec_ram_ctrl.sv
// tb_dec_ram_ctrl: directed bench for dec_ram_ctrl; an 8-bit-frame instance (dut_a) and a
// 256-bit-frame instance (dut_b) share stimulus, sel picks whose outputs are observed.
module tb_dec_ram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_bit = 1'b0;
  logic rd_ready = 1'b1;
  logic sel = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dec_ram_ctrl_if #(.A_WIDTH(3)) ifa ();
  dec_ram_ctrl_if #(.A_WIDTH(8)) ifb ();

  dec_ram_ctrl #(.A_WIDTH(3), .N_BITS(8))   dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dec_ram_ctrl #(.A_WIDTH(8), .N_BITS(256)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic mem_a [0:15];
  logic mem_b [0:511];
  logic dout_a = 1'b0;
  logic dout_b = 1'b0;

  assign ifa.wr_valid = wr_valid;
  assign ifa.wr_bit   = wr_bit;
  assign ifa.rd_ready = rd_ready;
  assign ifa.ram_dout = dout_a;
  assign ifb.wr_valid = wr_valid;
  assign ifb.wr_bit   = wr_bit;
  assign ifb.rd_ready = rd_ready;
  assign ifb.ram_dout = dout_b;

  // Behavioural single-port RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (ifa.ram_cs) begin
      if (ifa.ram_we) mem_a[{ifa.ram_rs, ifa.ram_addr}] <= ifa.ram_din;
      else dout_a <= mem_a[{ifa.ram_rs, ifa.ram_addr}];
    end
    if (ifb.ram_cs) begin
      if (ifb.ram_we) mem_b[{ifb.ram_rs, ifb.ram_addr}] <= ifb.ram_din;
      else dout_b <= mem_b[{ifb.ram_rs, ifb.ram_addr}];
    end
  end

  wire       o_wr_ready = sel ? ifb.wr_ready : ifa.wr_ready;
  wire       o_rd_valid = sel ? ifb.rd_valid : ifa.rd_valid;
  wire       o_rd_bit   = sel ? ifb.rd_bit   : ifa.rd_bit;
  wire       o_rd_last  = sel ? ifb.rd_last  : ifa.rd_last;
  wire [1:0] o_full     = sel ? ifb.bank_full : ifa.bank_full;
  wire       o_cs       = sel ? ifb.ram_cs   : ifa.ram_cs;
  wire       o_we       = sel ? ifb.ram_we   : ifa.ram_we;
  wire       o_rs       = sel ? ifb.ram_rs   : ifa.ram_rs;
  wire [7:0] o_addr     = sel ? ifb.ram_addr : {5'b00000, ifa.ram_addr};

  logic       rd_bits [$];
  logic       rd_lasts [$];
  logic       cs_we [$];
  logic       wr_rs [$];
  logic [7:0] wr_addr [$];
  int         rdv_cnt = 0;
  logic       seen_b0a7 = 1'b0;

  // Monitor on the falling edge, midway between input changes and the active edge.
  always @(negedge clk) begin
    if (o_rd_valid && rd_ready) begin
      rd_bits.push_back(o_rd_bit);
      rd_lasts.push_back(o_rd_last);
    end
    if (o_rd_valid) rdv_cnt = rdv_cnt + 1;
    if (o_cs) cs_we.push_back(o_we);
    if (o_cs && o_we) begin
      wr_rs.push_back(o_rs);
      wr_addr.push_back(o_addr);
    end
    if (o_cs && !o_we && !o_rs && o_addr == 8'd7) seen_b0a7 = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_bits.delete();
    rd_lasts.delete();
    cs_we.delete();
    wr_rs.delete();
    wr_addr.delete();
    rdv_cnt = 0;
    seen_b0a7 = 1'b0;
  endtask

  task automatic rst_pulse(input int n);
    wr_valid = 1'b0;
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Offer one bit and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic write_bit(input logic b);
    int n;
    wr_valid = 1'b1;
    wr_bit = b;
    for (n = 0; n < 200; n++) begin
      #1;
      if (o_wr_ready) break;
      @(posedge clk);
      #1;
    end
    if (n >= 200) chk("wr_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reads(input int n, input int bound);
    for (int k = 0; k < bound && rd_bits.size() < n; k++) tick();
    if (rd_bits.size() < n) chk("rd_timeout", 32'(rd_bits.size()), 32'(n));
  endtask

  function automatic logic fd_bit(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'd37 + 32'd11;
    return v[3] ^ v[6];
  endfunction

  localparam logic [7:0] PAT_A = 8'h4D;  // 1,0,1,1,0,0,1,0 from bit 0
  localparam logic [7:0] PAT_C = 8'h36;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] lst;
    logic [7:0]  pat_a;
    logic [7:0]  pat_c;
    logic [3:0]  wev;
    int          bad;
    int          nl;
    pat_a = PAT_A;
    pat_c = PAT_C;

    // Reset with wr_valid high.
    rst = 1'b1; wr_valid = 1'b1; wr_bit = 1'b1; rd_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      chk("rst_wr_ready", 32'(o_wr_ready), 32'd0);
      chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
      chk("rst_cs", 32'(o_cs), 32'd0);
      chk("rst_full", 32'(o_full), 32'd0);
    end
    rst = 1'b0; #1;
    chk("post_rst_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("post_rst_addr", 32'(o_addr), 32'd0);
    chk("post_rst_rs", 32'(o_rs), 32'd0);
    wr_valid = 1'b0;
    tick();

    // Single frame with the reader always ready.
    rst_pulse(1); clear_mon();
    for (int i = 0; i < 8; i++) write_bit(pat_a[i]);
    wr_valid = 1'b0; #1;
    chk("sf_full_01", 32'(o_full), 32'd1);
    chk("sf_rd_grant_cs", 32'(o_cs), 32'd1);
    chk("sf_rd_grant_we", 32'(o_we), 32'd0);
    tick(); #1;
    chk("sf_lat_t1", 32'(o_rd_valid), 32'd0);
    tick(); #1;
    chk("sf_lat_t2", 32'(o_rd_valid), 32'd1);
    chk("sf_first_bit", 32'(o_rd_bit), 32'd1);
    tick();
    wait_reads(8, 100);
    got = 16'h0; lst = 16'h0;
    for (int i = 0; i < 8 && i < rd_bits.size(); i++) begin
      got[i] = rd_bits[i];
      lst[i] = rd_lasts[i];
    end
    chk("sf_bits", 32'(got), 32'(pat_a));
    chk("sf_last", 32'(lst), 32'h80);
    chk("sf_full_00", 32'(o_full), 32'd0);

    // Backpressure: two frames with the reader stalled.
    rst_pulse(1); clear_mon(); rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_bit(pat_a[i]);
    for (int i = 0; i < 8; i++) write_bit(pat_c[i]);
    wr_bit = 1'b0;
    repeat (4) tick();
    #1;
    chk("bp_full_11", 32'(o_full), 32'd3);
    chk("bp_wr_ready", 32'(o_wr_ready), 32'd0);
    chk("bp_rd_valid", 32'(o_rd_valid), 32'd1);
    chk("bp_rd_bit", 32'(o_rd_bit), 32'(pat_a[0]));
    chk("bp_fifo_occ", 32'(dut_a.fifo_occ_r), 32'd2);
    chk("bp_no_grant", 32'(o_cs), 32'd0);
    tick(); #1;
    chk("bp_rd_bit_stable", 32'(o_rd_bit), 32'(pat_a[0]));
    tick();
    seen_b0a7 = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (o_wr_ready) break;
      @(posedge clk); #1;
    end
    chk("bp_wr_ready_back", 32'(o_wr_ready), 32'd1);
    chk("bp_after_b0a7", 32'(seen_b0a7), 32'd1);
    wr_valid = 1'b0;
    tick();
    wait_reads(16, 200);
    got = 16'h0; lst = 16'h0;
    for (int i = 0; i < 16 && i < rd_bits.size(); i++) begin
      got[i] = rd_bits[i];
      lst[i] = rd_lasts[i];
    end
    chk("bp_bits", 32'(got), 32'({pat_c, pat_a}));
    chk("bp_last", 32'(lst), 32'h8080);

    // Contention: bank 0 full, bank 1 filling, reader ready.
    rst_pulse(1); clear_mon(); rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_bit(pat_a[i]);
    for (int i = 0; i < 8; i++) write_bit(pat_c[i]);
    wr_valid = 1'b0;
    wait_reads(16, 200);
    got = 16'h0; wev = 4'h0;
    for (int i = 0; i < 8 && i < cs_we.size(); i++) got[i] = cs_we[i];
    for (int i = 0; i < 4 && i + 8 < cs_we.size(); i++) wev[i] = cs_we[i + 8];
    chk("ct_first_writes", 32'(got), 32'hFF);
`ifdef DEC_RAM_CTRL_WR_PRIO_EN
    chk("ct_we_seq", 32'(wev), 32'hF);
`else
    chk("ct_we_seq", 32'(wev), 32'h5);
`endif
    got = 16'h0;
    for (int i = 0; i < 16 && i < rd_bits.size(); i++) got[i] = rd_bits[i];
    chk("ct_bits", 32'(got), 32'({pat_c, pat_a}));

    // Reset in the middle of a frame.
    rst_pulse(1);
    for (int i = 0; i < 3; i++) write_bit(1'b1);
    rst_pulse(1); clear_mon();
    for (int i = 0; i < 8; i++) write_bit(pat_c[i]);
    wr_valid = 1'b0;
    chk("mf_rd_valid_quiet", 32'(rdv_cnt), 32'd0);
    chk("mf_nwrites", 32'(wr_rs.size()), 32'd8);
    if (wr_rs.size() > 0) begin
      chk("mf_first_rs", 32'(wr_rs[0]), 32'd0);
      chk("mf_first_addr", 32'(wr_addr[0]), 32'd0);
    end
    wait_reads(8, 100);
    got = 16'h0;
    for (int i = 0; i < 8 && i < rd_bits.size(); i++) got[i] = rd_bits[i];
    chk("mf_bits", 32'(got), 32'(pat_c));

    // Full depth on the 256-bit instance: two frames through both banks.
    sel = 1'b1;
    rst_pulse(2); clear_mon(); rd_ready = 1'b1;
    for (int i = 0; i < 512; i++) write_bit(fd_bit(i));
    wr_valid = 1'b0;
    wait_reads(512, 2000);
    chk("fd_nwrites", 32'(wr_addr.size()), 32'd512);
    bad = 0;
    for (int i = 0; i < 512 && i < wr_addr.size(); i++) begin
      if (wr_addr[i] != 8'(i) || wr_rs[i] != ((i >= 256) ? 1'b1 : 1'b0)) bad = bad + 1;
    end
    chk("fd_wr_addr_errs", 32'(bad), 32'd0);
    if (wr_addr.size() >= 257) begin
      chk("fd_addr_255", 32'({wr_rs[255], wr_addr[255]}), 32'h0FF);
      chk("fd_addr_wrap", 32'({wr_rs[256], wr_addr[256]}), 32'h100);
    end
    bad = 0; nl = 0;
    for (int i = 0; i < rd_bits.size(); i++) begin
      if (rd_bits[i] !== fd_bit(i)) bad = bad + 1;
      if (rd_lasts[i]) nl = nl + 1;
    end
    chk("fd_rd_errs", 32'(bad), 32'd0);
    chk("fd_nreads", 32'(rd_bits.size()), 32'd512);
    chk("fd_last_count", 32'(nl), 32'd2);
    if (rd_lasts.size() >= 512) chk("fd_last_pos", 32'({rd_lasts[511], rd_lasts[255]}), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
